// File: rtl/qfrag_ctrl_seq.sv
`timescale 1ns/1ps
// qfrag_ctrl_seq
// Registered control sequencer for a bank of N logic-cell flip-flops. It turns
// single-beat requests (load from QDI, load from CZI, set, clear) into
// glitch-free pin waveforms. Every output comes straight from a flop because
// the bank's set/reset pins are asynchronous.
//
// Ports:
//   QCK        clock, rising edge
//   QRT        synchronous active-high reset
//   REQ_VALID  request present
//   REQ_READY  request accepted when REQ_VALID && REQ_READY at a QCK edge
//   REQ_OP     00 load QDI, 01 load CZI, 10 set, 11 clear
//   REQ_MASK   per-flop select
//   REQ_DATA   direct data for op 00
//   QST_O      flop set pins
//   QRT_O      flop reset pins
//   QEN_O      flop enable pins
//   QDS_O      data-select (1 = QDI, 0 = CZI)
//   QDI_O      flop direct-data pins
//   BUSY       high while not IDLE
//   DONE       one-cycle completion pulse (first IDLE cycle after an op)
module qfrag_ctrl_seq #(
    parameter int N         = 8,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic         QCK,
    input  logic         QRT,
    input  logic         REQ_VALID,
    output logic         REQ_READY,
    input  logic [1:0]   REQ_OP,
    input  logic [N-1:0] REQ_MASK,
    input  logic [N-1:0] REQ_DATA,
    output logic [N-1:0] QST_O,
    output logic [N-1:0] QRT_O,
    output logic [N-1:0] QEN_O,
    output logic         QDS_O,
    output logic [N-1:0] QDI_O,
    output logic         BUSY,
    output logic         DONE
);

    typedef enum logic [1:0] {IDLE, PULSE, RECOVER, LOAD} state_t;

    localparam logic [3:0] PULSE_M1 = 4'(PULSE_CYC - 1);
    localparam logic [3:0] HOLD_M1  = 4'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

    state_t       state;
    logic [3:0]   cnt;     // remaining cycles in PULSE/RECOVER after this one
    logic         clr_q;   // captured op: 1 = clear, 0 = set
    logic [N-1:0] mask_q;

    // Outputs are computed for the state being entered, so every pin is a
    // flop and the waveform for cycle k is ready at the edge that starts it.
    // LOAD lasts a single cycle, so its data goes directly into the QDI_O
    // flops at acceptance; only the pulse op and mask need to be held.
    always_ff @(posedge QCK) begin
        if (QRT) begin
            state     <= IDLE;
            cnt       <= '0;
            clr_q     <= 1'b0;
            mask_q    <= '0;
            QST_O     <= '0;
            QRT_O     <= '0;
            QEN_O     <= '0;
            QDS_O     <= 1'b0;
            QDI_O     <= '0;
            REQ_READY <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            QST_O     <= '0;
            QRT_O     <= '0;
            QEN_O     <= '0;
            QDS_O     <= 1'b0;
            QDI_O     <= '0;
            REQ_READY <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            case (state)
                IDLE: begin
                    if (REQ_VALID && REQ_READY) begin
                        clr_q  <= REQ_OP[0];
                        mask_q <= REQ_MASK;
                        BUSY   <= 1'b1;
                        if (REQ_OP[1]) begin
                            state <= PULSE;
                            cnt   <= PULSE_M1;
                            if (REQ_OP[0]) QRT_O <= REQ_MASK;
                            else           QST_O <= REQ_MASK;
                        end else begin
                            state <= LOAD;
                            QEN_O <= REQ_MASK;
                            QDS_O <= ~REQ_OP[0];
                            QDI_O <= REQ_OP[0] ? '0 : (REQ_DATA & REQ_MASK);
                        end
                    end else begin
                        // Also covers the first cycle after reset release,
                        // where READY is still low and nothing is accepted.
                        REQ_READY <= 1'b1;
                    end
                end
                PULSE: begin
                    if (cnt != 4'd0) begin
                        cnt  <= cnt - 4'd1;
                        BUSY <= 1'b1;
                        if (clr_q) QRT_O <= mask_q;
                        else       QST_O <= mask_q;
                    end else if (HOLD_CYC == 0) begin
                        state     <= IDLE;
                        DONE      <= 1'b1;
                        REQ_READY <= 1'b1;
                    end else begin
                        state <= RECOVER;
                        cnt   <= HOLD_M1;
                        BUSY  <= 1'b1;
                    end
                end
                RECOVER: begin
                    if (cnt != 4'd0) begin
                        cnt  <= cnt - 4'd1;
                        BUSY <= 1'b1;
                    end else begin
                        state     <= IDLE;
                        DONE      <= 1'b1;
                        REQ_READY <= 1'b1;
                    end
                end
                default: begin  // LOAD: single enable cycle
                    state     <= IDLE;
                    DONE      <= 1'b1;
                    REQ_READY <= 1'b1;
                end
            endcase
        end
    end

endmodule
